vga_scan_engine: RTL and testbench
==================================

Name: vga_scan_engine

Overview:
- Parametrised VGA raster generator. It replaces the fixed 640x480 timing inside the display top level, which is fed by a 48 MHz HSOSC clock.
- Produces hsync/vsync, pixel coordinates for the SPI-loaded pixel source, frame and line strobes, and registered blanked RGB for the video DAC.
- Configurable timing, sync polarity, clock-to-pixel divider and colour depth.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel (>=1)
- COLOR_W, 4, bits per colour channel
- HSYNC_POL, 0, asserted level of hsync
- VSYNC_POL, 0, asserted level of vsync

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  run enable
- testMode  in  1  select test pattern (used only with the optional feature)
- rIn, gIn, bIn  in  COLOR_W each  pixel colour for the previous-tick x/y
- x  out  XW=$clog2(H_TOTAL)  current horizontal count
- y  out  YW=$clog2(V_TOTAL)  current vertical count
- active  out  1  x<H_ACTIVE and y<V_ACTIVE
- pixTick  out  1  pixel-advance strobe
- lineStart  out  1  last-pixel-of-line strobe
- frameStart  out  1  last-pixel-of-frame strobe
- hsync, vsync  out  1  to monitor
- rBlanked, gBlanked, bBlanked  out  COLOR_W each  to DAC

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Reset (reset=0, asynchronous):
  - divCnt, hcnt and vcnt go to 0.
  - RGB outputs go to 0.
  - hsync/vsync go to their deasserted level (~POL).
  - Strobes go to 0.
- Divider:
  - divCnt counts 0..CLK_DIV-1 while en=1.
  - pixTick = en && divCnt==CLK_DIV-1 (combinational). With CLK_DIV=1, pixTick=en.
- Counters advance only on pixTick.
  - hcnt increments and wraps H_TOTAL-1 -> 0.
  - On that wrap, vcnt increments and wraps V_TOTAL-1 -> 0.
- x=hcnt, y=vcnt, active: combinational from the counters.
- lineStart = pixTick && hcnt==H_TOTAL-1.
- frameStart = lineStart && vcnt==V_TOTAL-1.
- Output pipeline, 1 pixel latency. On each pixTick, output registers capture:
  - hsyncReg = POL when hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else ~POL.
  - vsyncReg, same rule using vcnt and the V parameters.
  - RGB = active ? {rIn,gIn,bIn} : 0.
  - The pixel source therefore has exactly one pixTick to return colour for x/y.
- Outputs hold between ticks.
- en falling:
  - On the next clk, divCnt, hcnt and vcnt clear to 0.
  - RGB clears to 0; syncs go deasserted; strobes stay 0.
  - Raster restarts at (0,0) when en returns.
- Simultaneous wraps: both counters wrap to (0,0) on one tick when hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1. frameStart and lineStart both pulse on that tick.
- Reset mid-line: immediate asynchronous clear; no partial sync pulse is extended.
- Widths: all comparisons unsigned at XW/YW bits; no truncation is allowed for the chosen parameters.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined, testMode=1, active pixel: colour comes from 8 vertical bars, ignoring rIn/gIn/bIn.
  - bar = (hcnt*8)/H_ACTIVE.
  - Each channel is all-ones or zero: r=bar[2], g=bar[1], b=bar[0].
  - Latency and blanking are unchanged.
- Defined, testMode=0: normal path.
- Not defined: testMode is ignored and no bar logic is synthesised.

Test Plan:
- Reset/idle: hold reset=0, then release with en=0 -> hsync=vsync=1 (POL=0), RGB=0, x=y=0, no pixTick for 100 clks.
- Small-timing raster: H 8/2/2/2, V 4/1/1/1, CLK_DIV=2, en=1 -> pixTick every 2nd clk; hsync low for exactly 2 ticks starting 1 tick after hcnt=10; vsync low for 1 line; frameStart every 14*7=98 ticks.
- Latency/blank: drive rIn=hcnt[3:0], gIn=F, bIn=5 -> rBlanked equals the hcnt of the previous tick while active; RGB=0 on every tick with hcnt>=8 or vcnt>=4.
- Wrap: at hcnt=13, vcnt=6 -> lineStart and frameStart both 1 for one clk; next tick x=y=0.
- en drop mid-line at hcnt=5, vcnt=2 -> next clk counters 0, RGB 0, syncs high; on re-enable first pixTick is at divCnt=1.
- VGA_TEST_PATTERN_EN with testMode=1, H_ACTIVE=8 -> pixel x=5 outputs r=F, g=0, b=F one tick later; inputs ignored.

Source files
------------

// File: rtl/vga_scan_engine.sv
// ============================================================================
// vga_scan_engine : parametrised VGA raster generator with 1-pixel output pipe
// Optional bar test pattern: define VGA_TEST_PATTERN_EN.   Revision: 1.0
// ============================================================================
`default_nettype none

module vga_scan_engine #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int CLK_DIV   = 2,
   parameter int COLOR_W   = 4,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int XW       = $clog2(H_TOTAL),
   localparam int YW       = $clog2(V_TOTAL)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               testMode,
   input  logic [COLOR_W-1:0] rIn,
   input  logic [COLOR_W-1:0] gIn,
   input  logic [COLOR_W-1:0] bIn,
   output logic [XW-1:0]      x,
   output logic [YW-1:0]      y,
   output logic               active,
   output logic               pixTick,
   output logic               lineStart,
   output logic               frameStart,
   output logic               hsync,
   output logic               vsync,
   output logic [COLOR_W-1:0] rBlanked,
   output logic [COLOR_W-1:0] gBlanked,
   output logic [COLOR_W-1:0] bBlanked
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
   localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
   localparam logic [XW-1:0] H_VIS    = XW'(H_ACTIVE);
   localparam logic [YW-1:0] V_VIS    = YW'(V_ACTIVE);
   localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
   localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
   localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [DW-1:0]      div_cnt_q, div_cnt_d;
   logic [XW-1:0]      hcnt_q, hcnt_d;
   logic [YW-1:0]      vcnt_q, vcnt_d;
   logic               hsync_q, hsync_d;
   logic               vsync_q, vsync_d;
   logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
   logic               h_last, v_last, in_hs, in_vs;
   logic [COLOR_W-1:0] r_src, g_src, b_src;

`ifdef VGA_TEST_PATTERN_EN
   logic [XW+2:0] bar_full;
   logic [2:0]    bar;

   // Only meaningful while active, where hcnt < H_ACTIVE keeps bar below 8.
   always_comb begin
      bar_full = (XW+3)'({hcnt_q, 3'b000} / (XW+3)'(H_ACTIVE));
      bar      = bar_full[2:0];
      r_src    = testMode ? {COLOR_W{bar[2]}} : rIn;
      g_src    = testMode ? {COLOR_W{bar[1]}} : gIn;
      b_src    = testMode ? {COLOR_W{bar[0]}} : bIn;
   end
`else
   logic unused_test_mode;
   assign unused_test_mode = testMode;

   always_comb begin
      r_src = rIn;
      g_src = gIn;
      b_src = bIn;
   end
`endif

   always_comb begin
      h_last     = (hcnt_q == H_LAST);
      v_last     = (vcnt_q == V_LAST);
      in_hs      = (hcnt_q >= HS_START) && (hcnt_q <= HS_END);
      in_vs      = (vcnt_q >= VS_START) && (vcnt_q <= VS_END);
      active     = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
      // Gated by reset so strobes are low during reset even when CLK_DIV=1.
      pixTick    = en && reset && (div_cnt_q == DIV_LAST);
      lineStart  = pixTick && h_last;
      frameStart = lineStart && v_last;

      div_cnt_d = div_cnt_q;
      hcnt_d    = hcnt_q;
      vcnt_d    = vcnt_q;
      hsync_d   = hsync_q;
      vsync_d   = vsync_q;
      r_d       = r_q;
      g_d       = g_q;
      b_d       = b_q;

      if (!en) begin
         div_cnt_d = '0;
         hcnt_d    = '0;
         vcnt_d    = '0;
         hsync_d   = ~HSYNC_POL;
         vsync_d   = ~VSYNC_POL;
         r_d       = '0;
         g_d       = '0;
         b_d       = '0;
      end else if (pixTick) begin
         div_cnt_d = '0;
         hcnt_d    = h_last ? '0 : hcnt_q + 1'b1;
         if (h_last) vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
         hsync_d   = in_hs ? HSYNC_POL : ~HSYNC_POL;
         vsync_d   = in_vs ? VSYNC_POL : ~VSYNC_POL;
         r_d       = active ? r_src : '0;
         g_d       = active ? g_src : '0;
         b_d       = active ? b_src : '0;
      end else begin
         div_cnt_d = div_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt_q <= '0;
         hcnt_q    <= '0;
         vcnt_q    <= '0;
         hsync_q   <= ~HSYNC_POL;
         vsync_q   <= ~VSYNC_POL;
         r_q       <= '0;
         g_q       <= '0;
         b_q       <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
         hcnt_q    <= hcnt_d;
         vcnt_q    <= vcnt_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         r_q       <= r_d;
         g_q       <= g_d;
         b_q       <= b_d;
      end
   end

   assign x        = hcnt_q;
   assign y        = vcnt_q;
   assign hsync    = hsync_q;
   assign vsync    = vsync_q;
   assign rBlanked = r_q;
   assign gBlanked = g_q;
   assign bBlanked = b_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_scan_engine.sv
// ============================================================================
// tb_vga_scan_engine : directed bench for vga_scan_engine on a 14x7 raster
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vga_scan_engine;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       en;
   logic       testMode;
   logic       src_sel;
   logic [3:0] rIn, gIn, bIn;
   logic [3:0] x;
   logic [2:0] y;
   logic       active, pixTick, lineStart, frameStart, hsync, vsync;
   logic [3:0] rBlanked, gBlanked, bBlanked;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign rIn = src_sel ? x : 4'h3;
   assign gIn = src_sel ? 4'hF : 4'h3;
   assign bIn = src_sel ? 4'h5 : 4'h3;

   vga_scan_engine #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .CLK_DIV(2), .COLOR_W(4), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
   ) dut (
      .clk(clk), .reset(reset_n), .en(en), .testMode(testMode),
      .rIn(rIn), .gIn(gIn), .bIn(bIn),
      .x(x), .y(y), .active(active), .pixTick(pixTick),
      .lineStart(lineStart), .frameStart(frameStart),
      .hsync(hsync), .vsync(vsync),
      .rBlanked(rBlanked), .gBlanked(gBlanked), .bBlanked(bBlanked)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic seen_tick;
      reset_n = 1'b0; en = 1'b0; testMode = 1'b0; src_sel = 1'b1;
      repeat (3) step();
      n_checks++;
      if ({hsync, vsync} !== 2'b11) begin
         n_fail++; $display("FAIL reset_sync got %b required 11", {hsync, vsync});
      end
      n_checks++;
      if ({rBlanked, gBlanked, bBlanked} !== 12'h000) begin
         n_fail++; $display("FAIL reset_rgb got %h required 000", {rBlanked, gBlanked, bBlanked});
      end
      n_checks++;
      if ({x, y, pixTick, lineStart, frameStart} !== 10'd0) begin
         n_fail++; $display("FAIL reset_xy x=%0d y=%0d strobes=%b required all 0", x, y, {pixTick, lineStart, frameStart});
      end
      reset_n = 1'b1;
      seen_tick = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (pixTick !== 1'b0 || x !== 4'd0 || hsync !== 1'b1) seen_tick = 1'b1;
      end
      n_checks++;
      if (seen_tick !== 1'b0) begin
         n_fail++; $display("FAIL idle_en0 activity got 1 required 0");
      end
   endtask

   task automatic test_raster();
      int n, h, v, hp, vp;
      logic e_tick, e_ls, e_fs, e_hs, e_vs;
      logic [11:0] e_rgb;
      en = 1'b1;
      for (int c = 1; c <= 420; c++) begin
         step();
         n = c / 2;
         h = n % 14;
         v = (n / 14) % 7;
         e_tick = (c % 2) == 1;
         e_ls   = e_tick && (h == 13);
         e_fs   = e_ls && (v == 6);
         if (n == 0) begin
            e_hs = 1'b1; e_vs = 1'b1; e_rgb = 12'h000;
         end else begin
            hp = (n - 1) % 14;
            vp = ((n - 1) / 14) % 7;
            e_hs  = !(hp == 10 || hp == 11);
            e_vs  = !(vp == 5);
            e_rgb = (hp < 8 && vp < 4) ? {4'(hp), 4'hF, 4'h5} : 12'h000;
         end
         n_checks++;
         if (x !== 4'(h) || y !== 3'(v)) begin
            n_fail++; $display("FAIL raster_xy c=%0d got %0d,%0d required %0d,%0d", c, x, y, h, v);
         end
         n_checks++;
         if (active !== (h < 8 && v < 4)) begin
            n_fail++; $display("FAIL raster_active c=%0d got %b", c, active);
         end
         n_checks++;
         if ({pixTick, lineStart, frameStart} !== {e_tick, e_ls, e_fs}) begin
            n_fail++; $display("FAIL raster_strobes c=%0d got %b required %b", c, {pixTick, lineStart, frameStart}, {e_tick, e_ls, e_fs});
         end
         n_checks++;
         if ({hsync, vsync} !== {e_hs, e_vs}) begin
            n_fail++; $display("FAIL raster_sync c=%0d got %b required %b", c, {hsync, vsync}, {e_hs, e_vs});
         end
         n_checks++;
         if ({rBlanked, gBlanked, bBlanked} !== e_rgb) begin
            n_fail++; $display("FAIL raster_rgb c=%0d got %h required %h", c, {rBlanked, gBlanked, bBlanked}, e_rgb);
         end
      end
   endtask

   task automatic test_wrap();
      logic found = 1'b0;
      for (int i = 0; i < 500 && !found; i++) begin
         step();
         if (x == 4'd13 && y == 3'd6 && pixTick) found = 1'b1;
      end
      n_checks++;
      if ({found, lineStart, frameStart} !== 3'b111) begin
         n_fail++; $display("FAIL wrap_strobes got found/ls/fs=%b required 111", {found, lineStart, frameStart});
      end
      step();
      n_checks++;
      if ({x, y, lineStart, frameStart} !== 9'd0) begin
         n_fail++; $display("FAIL wrap_next x=%0d y=%0d ls=%b fs=%b required 0,0,0,0", x, y, lineStart, frameStart);
      end
   endtask

   task automatic test_en_drop();
      logic found = 1'b0;
      for (int i = 0; i < 500 && !found; i++) begin
         step();
         if (x == 4'd5 && y == 3'd2) found = 1'b1;
      end
      n_checks++;
      if ({found, rBlanked} !== {1'b1, 4'd4}) begin
         n_fail++; $display("FAIL endrop_pre found=%b r=%h required 1,4", found, rBlanked);
      end
      en = 1'b0;
      step();
      n_checks++;
      if ({x, y, rBlanked, gBlanked, bBlanked, hsync, vsync, pixTick} !== {7'd0, 12'h000, 2'b11, 1'b0}) begin
         n_fail++; $display("FAIL endrop_clear x=%0d y=%0d rgb=%h sync=%b tick=%b required 0,0,000,11,0", x, y, {rBlanked, gBlanked, bBlanked}, {hsync, vsync}, pixTick);
      end
      repeat (3) step();
      en = 1'b1;
      #1;
      n_checks++;
      if (pixTick !== 1'b0) begin
         n_fail++; $display("FAIL reenable_div0 tick got %b required 0", pixTick);
      end
      step();
      n_checks++;
      if ({pixTick, x, y} !== {1'b1, 7'd0}) begin
         n_fail++; $display("FAIL reenable_div1 tick=%b x=%0d y=%0d required 1,0,0", pixTick, x, y);
      end
      step();
      n_checks++;
      if (x !== 4'd1) begin
         n_fail++; $display("FAIL reenable_adv x got %0d required 1", x);
      end
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         step();
         if (hsync == 1'b0) found = 1'b1;
      end
      en = 1'b0;
      step();
      n_checks++;
      if ({found, hsync} !== 2'b11) begin
         n_fail++; $display("FAIL endrop_sync found=%b hsync=%b required 1,1", found, hsync);
      end
      en = 1'b1;
   endtask

   task automatic test_reset_midline();
      logic found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         step();
         if (hsync == 1'b0) found = 1'b1;
      end
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if ({found, x, y, hsync, vsync, pixTick, rBlanked, gBlanked, bBlanked} !== {1'b1, 7'd0, 2'b11, 1'b0, 12'h000}) begin
         n_fail++; $display("FAIL reset_midline found=%b x=%0d y=%0d sync=%b tick=%b rgb=%h", found, x, y, {hsync, vsync}, pixTick, {rBlanked, gBlanked, bBlanked});
      end
      step();
      reset_n = 1'b1;
   endtask

`ifdef VGA_TEST_PATTERN_EN
   task automatic test_pattern();
      logic [3:0]  xs [3] = '{4'd5, 4'd7, 4'd2};
      logic [11:0] er [3] = '{12'hF0F, 12'hFFF, 12'h0F0};
      logic found;
      reset_n = 1'b0; en = 1'b0;
      step();
      reset_n = 1'b1; testMode = 1'b1; src_sel = 1'b0; en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         found = 1'b0;
         for (int i = 0; i < 300 && !found; i++) begin
            step();
            if (pixTick && x == xs[k] && y < 3'd4) found = 1'b1;
         end
         step();
         n_checks++;
         if ({found, rBlanked, gBlanked, bBlanked} !== {1'b1, er[k]}) begin
            n_fail++; $display("FAIL pattern_x%0d found=%b rgb=%h required %h", xs[k], found, {rBlanked, gBlanked, bBlanked}, er[k]);
         end
      end
      testMode = 1'b0; src_sel = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_raster();
      test_wrap();
      test_en_drop();
      test_reset_midline();
`ifdef VGA_TEST_PATTERN_EN
      test_pattern();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
